// File: rtl/latch_ex_mem_hs.sv
// EX->MEM pipeline register with valid/ready handshake, flush, optional skid entry
// and a saturating stall-cycle counter.
module latch_ex_mem_hs #(
    parameter int B    = 32,
    parameter int W    = 5,
    parameter int OPW  = 6,
    parameter int SKID = 1,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [B-1:0]    alu_result_in,
    input  logic [B-1:0]    r_data2_in,
    input  logic [W-1:0]    mux_RegDst_in,
    input  logic            wb_RegWrite_in,
    input  logic            wb_MemtoReg_in,
    input  logic            m_MemWrite_in,
    input  logic [OPW-1:0]  opcode_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [B-1:0]    alu_result_out,
    output logic [B-1:0]    r_data2_out,
    output logic [W-1:0]    mux_RegDst_out,
    output logic            wb_RegWrite_out,
    output logic            wb_MemtoReg_out,
    output logic            m_MemWrite_out,
    output logic [OPW-1:0]  opcode_out,
    input  logic            cnt_clr,
    output logic [CNTW-1:0] stall_cnt,
    output logic [1:0]      fsm_state
);

    localparam int EW = 2*B + W + 3 + OPW;
    localparam logic [CNTW-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Handshake: a transfer happens on a side exactly in the cycle where both
    // its valid and ready are high; valid never waits on ready.
    state_t          state, state_n;
    logic [EW-1:0]   main_q, skid_q, in_ent;
    logic            armed;
    logic            in_fire, out_fire;
    logic            load_main_in, load_main_skid, load_skid;
    logic            rw_raw, mtr_raw, mw_raw;
    logic [CNTW-1:0] cnt;

    assign in_ent = {alu_result_in, r_data2_in, mux_RegDst_in,
                     wb_RegWrite_in, wb_MemtoReg_in, m_MemWrite_in, opcode_in};

    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign fsm_state = state;

    // With a skid entry in_ready comes from registered state only; the
    // single-entry variant trades that for a combinational pass-through.
    assign in_ready = armed & ((SKID != 0) ? (state != FULL) : (!out_valid | out_ready));

    always_comb begin
        state_n        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        state_n      = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire && (SKID != 0)) begin
                        load_skid = 1'b1;
                        state_n   = FULL;
                    end else if (out_fire) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        state_n        = BUSY;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            state <= state_n;
            if (load_main_in) begin
                main_q <= in_ent;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_ent;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (out_valid && !out_ready && (cnt != '1)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign stall_cnt = cnt;

    // Data fields keep their last value when empty; control bits read as a NOP.
    assign {alu_result_out, r_data2_out, mux_RegDst_out,
            rw_raw, mtr_raw, mw_raw, opcode_out} = main_q;
    assign wb_RegWrite_out = rw_raw  & out_valid;
    assign wb_MemtoReg_out = mtr_raw & out_valid;
    assign m_MemWrite_out  = mw_raw  & out_valid;

endmodule

// File: tb/tb_latch_ex_mem_hs.sv
// Bench for latch_ex_mem_hs: a skid instance and a single-entry CNTW=3 instance share
// the same stimulus and are compared every cycle against a queue-based reference.
module tb_latch_ex_mem_hs;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  dst;
        logic        rw;
        logic        mtr;
        logic        mw;
        logic [5:0]  op;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [31:0] a;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_alu;
        logic [15:0] e_stall;
    } vec_t;

    logic        clk, reset;
    logic        in_valid, out_ready, flush, cnt_clr;
    logic [31:0] alu_result_in, r_data2_in;
    logic [4:0]  mux_RegDst_in;
    logic        wb_RegWrite_in, wb_MemtoReg_in, m_MemWrite_in;
    logic [5:0]  opcode_in;

    logic        in_ready0, out_valid0, rw0, mtr0, mw0;
    logic [31:0] alu0, rd20;
    logic [4:0]  dst0;
    logic [5:0]  op0;
    logic [15:0] stall_cnt0;
    logic [1:0]  st0;

    logic        in_ready1, out_valid1, rw1, mtr1, mw1;
    logic [31:0] alu1, rd21;
    logic [4:0]  dst1;
    logic [5:0]  op1;
    logic [2:0]  stall_cnt1;
    logic [1:0]  st1;

    ent_t o0, o1;
    assign o0 = {alu0, rd20, dst0, rw0, mtr0, mw0, op0};
    assign o1 = {alu1, rd21, dst1, rw1, mtr1, mw1, op1};

    latch_ex_mem_hs #(.SKID(1), .CNTW(16)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .alu_result_in(alu_result_in), .r_data2_in(r_data2_in), .mux_RegDst_in(mux_RegDst_in),
        .wb_RegWrite_in(wb_RegWrite_in), .wb_MemtoReg_in(wb_MemtoReg_in),
        .m_MemWrite_in(m_MemWrite_in), .opcode_in(opcode_in), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready),
        .alu_result_out(alu0), .r_data2_out(rd20), .mux_RegDst_out(dst0),
        .wb_RegWrite_out(rw0), .wb_MemtoReg_out(mtr0), .m_MemWrite_out(mw0),
        .opcode_out(op0), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt0), .fsm_state(st0)
    );

    latch_ex_mem_hs #(.SKID(0), .CNTW(3)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .alu_result_in(alu_result_in), .r_data2_in(r_data2_in), .mux_RegDst_in(mux_RegDst_in),
        .wb_RegWrite_in(wb_RegWrite_in), .wb_MemtoReg_in(wb_MemtoReg_in),
        .m_MemWrite_in(m_MemWrite_in), .opcode_in(opcode_in), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready),
        .alu_result_out(alu1), .r_data2_out(rd21), .mux_RegDst_out(dst1),
        .wb_RegWrite_out(rw1), .wb_MemtoReg_out(mtr1), .m_MemWrite_out(mw1),
        .opcode_out(op1), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt1), .fsm_state(st1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: an in-order queue per instance, capacity 2 (skid) or 1
    ent_t exp_q0[$];
    ent_t exp_q1[$];
    ent_t last_m[2];
    int   stall_m[2];
    logic armed_m;
    int   n_cmp, n_fail;
    vec_t tbl[21];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ent_t cur_in();
        return {alu_result_in, r_data2_in, mux_RegDst_in,
                wb_RegWrite_in, wb_MemtoReg_in, m_MemWrite_in, opcode_in};
    endfunction

    function automatic ent_t nop_mask(input ent_t e, input logic v);
        ent_t r = e;
        r.rw  = e.rw & v;
        r.mtr = e.mtr & v;
        r.mw  = e.mw & v;
        return r;
    endfunction

    function automatic logic mdl_ir0();
        return armed_m && (exp_q0.size() < 2);
    endfunction

    function automatic logic mdl_ir1();
        return armed_m && ((exp_q1.size() == 0) || out_ready);
    endfunction

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        last_m[0] = '0;
        last_m[1] = '0;
        stall_m[0] = 0;
        stall_m[1] = 0;
        armed_m = 1'b0;
    endtask

    task automatic model_compare();
        ent_t h0, h1;
        h0 = (exp_q0.size() > 0) ? exp_q0[0] : last_m[0];
        h1 = (exp_q1.size() > 0) ? exp_q1[0] : last_m[1];
        chk("d0_out_valid", out_valid0, exp_q0.size() > 0);
        chk("d0_in_ready", in_ready0, mdl_ir0());
        chk("d0_fields", o0, nop_mask(h0, exp_q0.size() > 0));
        chk("d0_stall_cnt", stall_cnt0, stall_m[0]);
        chk("d1_out_valid", out_valid1, exp_q1.size() > 0);
        chk("d1_in_ready", in_ready1, mdl_ir1());
        chk("d1_fields", o1, nop_mask(h1, exp_q1.size() > 0));
        chk("d1_stall_cnt", stall_cnt1, stall_m[1]);
    endtask

    task automatic model_update();
        logic f0, f1, v0, v1;
        f0 = in_valid && mdl_ir0();
        f1 = in_valid && mdl_ir1();
        v0 = exp_q0.size() > 0;
        v1 = exp_q1.size() > 0;
        if (reset) begin
            model_reset();
        end else begin
            if (cnt_clr) stall_m[0] = 0;
            else if (v0 && !out_ready && stall_m[0] < 65535) stall_m[0]++;
            if (cnt_clr) stall_m[1] = 0;
            else if (v1 && !out_ready && stall_m[1] < 7) stall_m[1]++;
            if (v0) last_m[0] = exp_q0[0];
            if (v1) last_m[1] = exp_q1[0];
            if (flush) begin
                exp_q0.delete();
                exp_q1.delete();
            end else begin
                if (v0 && out_ready) void'(exp_q0.pop_front());
                if (f0) exp_q0.push_back(cur_in());
                if (v1 && out_ready) void'(exp_q1.pop_front());
                if (f1) exp_q1.push_back(cur_in());
            end
            if (exp_q0.size() > 0) last_m[0] = exp_q0[0];
            if (exp_q1.size() > 0) last_m[1] = exp_q1[0];
            armed_m = 1'b1;
        end
    endtask

    // driver tasks: inputs change just after posedge, outputs sampled at negedge
    task automatic set_in(input logic iv, input logic [31:0] a, input logic ordy,
                          input logic fl, input logic clr);
        in_valid       = iv;
        alu_result_in  = a;
        r_data2_in     = ~a;
        mux_RegDst_in  = a[4:0];
        wb_RegWrite_in = 1'b1;
        wb_MemtoReg_in = a[0];
        m_MemWrite_in  = 1'b1;
        opcode_in      = a[5:0];
        out_ready      = ordy;
        flush          = fl;
        cnt_clr        = clr;
    endtask

    task automatic to_neg();
        @(negedge clk);
        model_compare();
    endtask

    task automatic to_pos();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] a, input logic ordy,
                                input logic fl, input logic clr, input logic e_ov,
                                input logic e_ir, input logic [31:0] e_alu,
                                input logic [15:0] e_stall);
        vec_t v;
        v.iv = iv; v.a = a; v.ordy = ordy; v.fl = fl; v.clr = clr;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_alu = e_alu; v.e_stall = e_stall;
        return v;
    endfunction

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        set_in(0, 32'h0, 0, 0, 0);
        model_reset();

        // stream, backpressure into FULL, flush in FULL and in BUSY
        tbl[0]  = mk(1, 32'h01, 1, 0, 0, 0, 1, 32'h00, 0);
        tbl[1]  = mk(1, 32'h02, 1, 0, 0, 1, 1, 32'h01, 0);
        tbl[2]  = mk(1, 32'h03, 1, 0, 0, 1, 1, 32'h02, 0);
        tbl[3]  = mk(1, 32'h04, 1, 0, 0, 1, 1, 32'h03, 0);
        tbl[4]  = mk(0, 32'h00, 1, 0, 0, 1, 1, 32'h04, 0);
        tbl[5]  = mk(0, 32'h00, 1, 0, 0, 0, 1, 32'h04, 0);
        tbl[6]  = mk(1, 32'h0A, 0, 0, 0, 0, 1, 32'h04, 0);
        tbl[7]  = mk(1, 32'h0B, 0, 0, 0, 1, 1, 32'h0A, 0);
        tbl[8]  = mk(0, 32'h00, 0, 0, 0, 1, 0, 32'h0A, 1);
        tbl[9]  = mk(0, 32'h00, 1, 0, 0, 1, 0, 32'h0A, 2);
        tbl[10] = mk(0, 32'h00, 1, 0, 0, 1, 1, 32'h0B, 2);
        tbl[11] = mk(0, 32'h00, 1, 0, 0, 0, 1, 32'h0B, 2);
        tbl[12] = mk(1, 32'h10, 0, 0, 0, 0, 1, 32'h0B, 2);
        tbl[13] = mk(1, 32'h11, 0, 0, 0, 1, 1, 32'h10, 2);
        tbl[14] = mk(1, 32'h0C, 0, 1, 0, 1, 0, 32'h10, 3);
        tbl[15] = mk(0, 32'h00, 1, 0, 0, 0, 1, 32'h10, 4);
        tbl[16] = mk(0, 32'h00, 1, 0, 1, 0, 1, 32'h10, 4);
        tbl[17] = mk(0, 32'h00, 1, 0, 0, 0, 1, 32'h10, 0);
        tbl[18] = mk(1, 32'h20, 1, 0, 0, 0, 1, 32'h10, 0);
        tbl[19] = mk(1, 32'h21, 1, 1, 0, 1, 1, 32'h20, 0);
        tbl[20] = mk(0, 32'h00, 1, 0, 0, 0, 1, 32'h20, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        to_neg();
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_in_ready", in_ready0, 0);
        chk("rst_fields", o0, 0);
        chk("rst_stall_cnt", stall_cnt0, 0);
        to_pos();
        reset = 1'b0;
        to_neg();
        to_pos();

        for (int i = 0; i < 21; i++) begin
            set_in(tbl[i].iv, tbl[i].a, tbl[i].ordy, tbl[i].fl, tbl[i].clr);
            to_neg();
            chk($sformatf("tbl%0d_out_valid", i), out_valid0, tbl[i].e_ov);
            chk($sformatf("tbl%0d_in_ready", i), in_ready0, tbl[i].e_ir);
            chk($sformatf("tbl%0d_alu_out", i), alu0, tbl[i].e_alu);
            chk($sformatf("tbl%0d_regwrite", i), rw0, tbl[i].e_ov);
            chk($sformatf("tbl%0d_memwrite", i), mw0, tbl[i].e_ov);
            chk($sformatf("tbl%0d_stall", i), stall_cnt0, tbl[i].e_stall);
            to_pos();
        end

        // single-entry instance: same-cycle in_ready, stall saturation at 7, clear
        set_in(1, 32'h30, 0, 0, 0);
        to_neg();
        chk("t6_ir_empty", in_ready1, 1);
        to_pos();
        for (int j = 0; j < 10; j++) begin
            set_in(1, 32'h31 + j, 0, 0, 0);
            to_neg();
            chk($sformatf("t6_ir_stall%0d", j), in_ready1, 0);
            chk($sformatf("t6_cnt%0d", j), stall_cnt1, (j < 7) ? j : 7);
            chk($sformatf("t6_hold%0d", j), alu1, 32'h30);
            to_pos();
        end
        set_in(1, 32'h40, 0, 0, 1);
        to_neg();
        chk("t6_cnt_sat", stall_cnt1, 7);
        to_pos();
        set_in(1, 32'h41, 1, 0, 0);
        to_neg();
        chk("t6_cnt_clr", stall_cnt1, 0);
        chk("t6_ir_comb", in_ready1, 1);
        to_pos();

        // random valid/ready/flush traffic, with low-ready windows
        for (int k = 0; k < 1000; k++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            alu_result_in  = $urandom;
            r_data2_in     = $urandom;
            mux_RegDst_in  = 5'($urandom_range(0, 31));
            wb_RegWrite_in = 1'($urandom_range(0, 1));
            wb_MemtoReg_in = 1'($urandom_range(0, 1));
            m_MemWrite_in  = 1'($urandom_range(0, 1));
            opcode_in      = 6'($urandom_range(0, 63));
            out_ready      = ((k / 100) % 2 == 1) ? ($urandom_range(0, 4) == 0)
                                                  : ($urandom_range(0, 1) == 1);
            flush          = ($urandom_range(0, 40) == 0);
            cnt_clr        = ($urandom_range(0, 60) == 0);
            to_neg();
            to_pos();
        end

        // reset asserted between edges mid-stream
        set_in(1, 32'h50, 0, 0, 0);
        to_neg();
        to_pos();
        set_in(1, 32'h51, 0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("t4_out_valid", out_valid0, 0);
        chk("t4_in_ready", in_ready0, 0);
        chk("t4_fields", o0, 0);
        chk("t4_stall_cnt", stall_cnt0, 0);
        chk("t4_fields1", o1, 0);
        model_reset();
        to_neg();
        to_pos();
        reset = 1'b0;
        set_in(1, 32'h55, 1, 0, 0);
        to_neg();
        chk("t4_ir_first", in_ready0, 0);
        to_pos();
        to_neg();
        chk("t4_ir_armed", in_ready0, 1);
        to_pos();
        set_in(0, 32'h0, 1, 0, 0);
        to_neg();
        chk("t4_out_valid_after", out_valid0, 1);
        chk("t4_alu_after", alu0, 32'h55);
        to_pos();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
